// File: rtl/seq_gen_arbiter_pkg.sv
// Shared types and constants for the sequence-generator arbiter.
package seq_gen_pkg;

   // Width of one generator byte on the output stream
   localparam int SEQ_DATA_W = 8;

   // Burst controller states
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Width of a requester index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_gen_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the search begins at 'ptr' and wraps.
// The pointer register itself lives in the parent.
module rr_arbiter
   import seq_gen_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any_req,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [ID_W-1:0]    win_idx
);

   assign any_req = |req;

   // First set request at or after ptr (modulo NUM_REQ) wins
   always_comb begin
      logic            found;
      logic [ID_W-1:0] cand;
      found      = 1'b0;
      cand       = '0;
      win_onehot = '0;
      win_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found            = 1'b1;
            win_idx          = cand;
            win_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_gen_arbiter.sv
// Shares one sequence generator among NUM_REQ requesters. One burst at a
// time, round-robin between bursts; the generator is advanced only on an
// accepted stream byte.
module seq_gen_arbiter
   import seq_gen_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int LEN_W   = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     gen_enable,
   input  logic [SEQ_DATA_W-1:0]    gen_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SEQ_DATA_W-1:0]    out_data,
   output logic [ID_W-1:0]          out_id,
   output logic                     out_last,
   output logic                     busy
);

   state_t             state_reg;
   logic [NUM_REQ-1:0] grant_reg;
   logic [ID_W-1:0]    id_reg;
   logic [ID_W-1:0]    ptr_reg;        // first requester searched on next pick
   logic [LEN_W-1:0]   remaining_reg;
   logic               valid_reg;
   logic               busy_reg;

   logic [LEN_W-1:0]   len_arr [NUM_REQ];
   logic               win_any;
   logic [NUM_REQ-1:0] win_onehot;
   logic [ID_W-1:0]    win_idx;
   logic [LEN_W-1:0]   win_len;
   logic [ID_W-1:0]    ptr_next;
   logic               transfer;
   logic               last_beat;

   // Unpack the flat length bus into one entry per requester
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
         assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req        (req),
      .ptr        (ptr_reg),
      .any_req    (win_any),
      .win_onehot (win_onehot),
      .win_idx    (win_idx)
   );

   assign win_len   = len_arr[win_idx];
   assign transfer  = valid_reg & out_ready;
   assign last_beat = (state_reg == STREAM) && (remaining_reg == LEN_W'(1));

   // After a burst the winner drops to lowest priority: search starts one past it
   assign ptr_next = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);

   assign grant      = grant_reg;
   assign out_valid  = valid_reg;
   assign busy       = busy_reg;
   assign out_id     = id_reg;
   assign out_last   = last_beat;
   assign out_data   = gen_data;
   // Generator steps exactly once per accepted byte, never while stalled
   assign gen_enable = transfer;

   // Burst FSM: pick a winner in IDLE, count accepted beats in STREAM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         id_reg        <= '0;
         ptr_reg       <= '0;
         remaining_reg <= '0;
         valid_reg     <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_any) begin
                  state_reg     <= STREAM;
                  grant_reg     <= win_onehot;
                  id_reg        <= win_idx;
                  // A zero length still delivers a single beat
                  remaining_reg <= (win_len == '0) ? LEN_W'(1) : win_len;
                  valid_reg     <= 1'b1;
                  busy_reg      <= 1'b1;
               end
            end
            STREAM: begin
               if (transfer) begin
                  if (last_beat) begin
                     state_reg     <= IDLE;
                     grant_reg     <= '0;
                     valid_reg     <= 1'b0;
                     busy_reg      <= 1'b0;
                     remaining_reg <= '0;
                     ptr_reg       <= ptr_next;
                  end else begin
                     remaining_reg <= remaining_reg - LEN_W'(1);
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               grant_reg <= '0;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Directed bench for seq_gen_arbiter with a behavioural sequence generator.
module tb_seq_gen_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [3:0]  grant;
   logic        gen_enable;
   logic [7:0]  gen_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   logic        out_last;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int gen_idx;
   int en_cnt;

   always #5 clk = ~clk;

   seq_gen_arbiter #(
      .NUM_REQ (4),
      .LEN_W   (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_len    (req_len),
      .grant      (grant),
      .gen_enable (gen_enable),
      .gen_data   (gen_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_last   (out_last),
      .busy       (busy)
   );

   // Expected generator byte sequence after reset
   function automatic logic [7:0] gen_byte(input int i);
      case (i)
         0:       return 8'hAF;
         1:       return 8'hBC;
         2:       return 8'hE2;
         3:       return 8'h78;
         4:       return 8'hFF;
         default: return 8'(i * 17);
      endcase
   endfunction

   // Generator model: advances on enable, restarts on reset; also counts enables
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gen_idx <= 0;
         en_cnt  <= 0;
      end else if (gen_enable) begin
         gen_idx <= gen_idx + 1;
         en_cnt  <= en_cnt + 1;
      end
   end
   assign gen_data = gen_byte(gen_idx);

   // One line per accepted byte
   always @(posedge clk) begin
      if (reset_n && out_valid && out_ready)
         $display("beat id=%0d data=%02h last=%0b grant=%b", out_id, out_data, out_last, grant);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_beat(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic [7:0] data, input logic last);
      check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
      check_val({tag, ".busy"},  32'(busy),      32'd1);
      check_val({tag, ".grant"}, 32'(grant),     32'(g));
      check_val({tag, ".id"},    32'(out_id),    32'(id));
      check_val({tag, ".data"},  32'(out_data),  32'(data));
      check_val({tag, ".last"},  32'(out_last),  32'(last));
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, ".valid"}, 32'(out_valid),  32'd0);
      check_val({tag, ".busy"},  32'(busy),       32'd0);
      check_val({tag, ".grant"}, 32'(grant),      32'd0);
      check_val({tag, ".last"},  32'(out_last),   32'd0);
      check_val({tag, ".gen_en"},32'(gen_enable), 32'd0);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req       = '0;
      req_len   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      check_idle("rst");
      check_val("rst.id", 32'(out_id), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Test 1: three-beat burst from requester 1
      do_reset();
      req = 4'b0010; req_len = 16'h0030;
      @(negedge clk);
      check_beat("t1.b0", 4'b0010, 2'd1, 8'hAF, 1'b0);
      check_val("t1.b0.gen_en", 32'(gen_enable), 32'd1);
      req = '0;
      @(negedge clk); check_beat("t1.b1", 4'b0010, 2'd1, 8'hBC, 1'b0);
      @(negedge clk); check_beat("t1.b2", 4'b0010, 2'd1, 8'hE2, 1'b1);
      @(negedge clk); check_idle("t1.end");
      check_val("t1.en_cnt", 32'(en_cnt), 32'd3);

      // Test 2: four-cycle stall on beat 2
      do_reset();
      req = 4'b0010; req_len = 16'h0030;
      @(negedge clk); check_beat("t2.b0", 4'b0010, 2'd1, 8'hAF, 1'b0);
      req = '0;
      @(negedge clk); check_beat("t2.b1", 4'b0010, 2'd1, 8'hBC, 1'b0);
      out_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         check_beat("t2.stall", 4'b0010, 2'd1, 8'hBC, 1'b0);
         check_val("t2.stall.gen_en", 32'(gen_enable), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk); check_beat("t2.b2", 4'b0010, 2'd1, 8'hE2, 1'b1);
      @(negedge clk); check_idle("t2.end");
      check_val("t2.en_cnt", 32'(en_cnt), 32'd3);

      // Test 3: all requesting, single beats, round-robin with idle gaps
      do_reset();
      req = 4'b1111; req_len = 16'h1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_beat("t3.beat", 4'(1 << (k % 4)), 2'(k % 4), gen_byte(k), 1'b1);
         if (k == 4) req = '0;
         @(negedge clk);
         check_idle("t3.gap");
      end
      check_val("t3.en_cnt", 32'(en_cnt), 32'd5);

      // Test 4: zero length means one beat
      do_reset();
      req = 4'b0100; req_len = 16'h0000;
      @(negedge clk); check_beat("t4.b0", 4'b0100, 2'd2, 8'hAF, 1'b1);
      req = '0;
      @(negedge clk); check_idle("t4.end");
      @(negedge clk); check_idle("t4.end2");
      check_val("t4.en_cnt", 32'(en_cnt), 32'd1);

      // Test 5: request dropped mid-burst, burst still completes
      do_reset();
      req = 4'b0001; req_len = 16'h0008;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_beat("t5.beat", 4'b0001, 2'd0, gen_byte(k), (k == 7));
         if (k == 1) req = '0;
      end
      @(negedge clk); check_idle("t5.end");
      check_val("t5.en_cnt", 32'(en_cnt), 32'd8);

      // Test 6: reset during beat 3 restores outputs and priority
      do_reset();
      req = 4'b0001; req_len = 16'h0001;
      @(negedge clk); check_beat("t6.pre", 4'b0001, 2'd0, 8'hAF, 1'b1);
      req = '0;
      @(negedge clk); check_idle("t6.gap");
      req = 4'b0100; req_len = 16'h0500;
      @(negedge clk); check_beat("t6.b0", 4'b0100, 2'd2, 8'hBC, 1'b0);
      req = '0;
      @(negedge clk); check_beat("t6.b1", 4'b0100, 2'd2, 8'hE2, 1'b0);
      @(negedge clk); check_beat("t6.b2", 4'b0100, 2'd2, 8'h78, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check_idle("t6.rst");
      check_val("t6.rst.id", 32'(out_id), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      req = 4'b1111; req_len = 16'h1111;
      @(negedge clk); check_beat("t6.after", 4'b0001, 2'd0, 8'hAF, 1'b1);
      req = '0;
      @(negedge clk); check_idle("t6.end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
